// File: rtl/dcache_lookup_master.sv
// -----------------------------------------------------------------------------
// dcache_lookup_master
//
// AXI master in front of the DRAM-cache storage slave. It takes one core
// request at a time and runs it to completion before taking the next:
//   - fill (req_write_i=1): AW then W then B. This installs a line.
//   - lookup (req_write_i=0): AR then R. The returned {tag,data} beat is
//     checked against the request address to produce hit, dirty and line data.
//
// Read beat layout (DATA_W+TAG_S bits, 576 by default):
//   [575] valid, [574] dirty, [573:542] stored tag (addr[63:32]),
//   [541:512] reserved, [511:0] line data.
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   req_*                      core request (valid/ready, write, addr, wdata)
//   resp_*                     core response (valid/ready, write, hit, dirty, rdata)
//   ar*/r*, aw*/w*/b*          AXI read and write channels to the storage slave
//   hit_cnt_o, miss_cnt_o      lookup statistics; these exist only when
//                              DCACHE_LOOKUP_STATS_EN is defined
//
// Optional feature macro: DCACHE_LOOKUP_STATS_EN
// -----------------------------------------------------------------------------
module dcache_lookup_master #(
    parameter int ID       = 1,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int TAG_S    = 64,
    parameter int INDEX_W  = 26,
    parameter int OFFSET_W = 6,
    parameter int ID_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [ADDR_W-1:0]         req_addr_i,
    input  logic [DATA_W-1:0]         req_wdata_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic                      resp_write_o,
    output logic                      resp_hit_o,
    output logic                      resp_dirty_o,
    output logic [DATA_W-1:0]         resp_rdata_o,
    output logic [ID_W-1:0]           arid_o,
    output logic [ADDR_W-1:0]         araddr_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    input  logic [ID_W-1:0]           rid_i,
    input  logic [DATA_W+TAG_S-1:0]   rdata_i,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    output logic [ID_W-1:0]           awid_o,
    output logic [ADDR_W-1:0]         awaddr_o,
    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [ID_W-1:0]           wid_o,
    output logic [DATA_W-1:0]         wdata_o,
    output logic                      wvalid_o,
    input  logic                      wready_i,
    input  logic [ID_W-1:0]           bid_i,
    input  logic                      bvalid_i,
    output logic                      bready_o
`ifdef DCACHE_LOOKUP_STATS_EN
    ,
    output logic [31:0]               hit_cnt_o,
    output logic [31:0]               miss_cnt_o
`endif
);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B, RESP} state_t;

    // The tag field holds the address bits above index+offset.
    localparam int BEAT_W    = DATA_W + TAG_S;
    localparam int TAG_LO    = INDEX_W + OFFSET_W;
    localparam int TAG_W     = ADDR_W - TAG_LO;
    localparam int VALID_BIT = BEAT_W - 1;
    localparam int DIRTY_BIT = BEAT_W - 2;
    localparam int TAG_MSB   = BEAT_W - 3;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_write_q, resp_write_d;
    logic                resp_hit_q, resp_hit_d;
    logic                resp_dirty_q, resp_dirty_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                tag_match;

    // The ID fields and the reserved beat bits are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{rid_i, bid_i, rdata_i[TAG_MSB-TAG_W:DATA_W]};

    assign tag_match = (rdata_i[TAG_MSB -: TAG_W] == addr_q[ADDR_W-1:TAG_LO]);

    always_comb begin
        // NOTE: every _d defaults to its _q first, so a branch that does not
        // assign a signal holds that signal and never infers a latch.
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        resp_valid_d = resp_valid_q;
        resp_write_d = resp_write_q;
        resp_hit_d   = resp_hit_q;
        resp_dirty_d = resp_dirty_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;

        // Each handshake input is examined only in the state that owns that
        // channel. A stray ready or response arriving in another state is
        // therefore ignored.
        unique case (state_q)
            IDLE: if (req_valid_i) begin
                addr_d      = req_addr_i;
                wdata_d     = req_wdata_i;
                req_ready_d = 1'b0;
                if (req_write_i) begin
                    awvalid_d = 1'b1;
                    state_d   = WR_AW;
                end else begin
                    arvalid_d = 1'b1;
                    state_d   = RD_AR;
                end
            end
            RD_AR: if (arready_i) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = RD_R;
            end
            RD_R: if (rvalid_i) begin
                rready_d     = 1'b0;
                resp_valid_d = 1'b1;
                resp_write_d = 1'b0;
                resp_hit_d   = rdata_i[VALID_BIT] & tag_match;
                resp_dirty_d = rdata_i[DIRTY_BIT];
                resp_rdata_d = rdata_i[DATA_W-1:0];
                state_d      = RESP;
            end
            // W is raised only after AW completes.
            WR_AW: if (awready_i) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b1;
                state_d   = WR_W;
            end
            WR_W: if (wready_i) begin
                wvalid_d = 1'b0;
                bready_d = 1'b1;
                state_d  = WR_B;
            end
            WR_B: if (bvalid_i) begin
                bready_d     = 1'b0;
                resp_valid_d = 1'b1;
                resp_write_d = 1'b1;
                resp_hit_d   = 1'b0;
                resp_dirty_d = 1'b0;
                resp_rdata_d = '0;
                state_d      = RESP;
            end
            // No bypass: the next request is taken in the following IDLE cycle.
            RESP: if (resp_ready_i) begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so that every flop
    // samples values from before the clock edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_dirty_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_write_q <= resp_write_d;
            resp_hit_q   <= resp_hit_d;
            resp_dirty_q <= resp_dirty_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

`ifdef DCACHE_LOOKUP_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Only lookup responses are counted, on the cycle the core accepts them.
    // Each counter stops at all-ones.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == RESP && resp_ready_i && !resp_write_q) begin
            if (resp_hit_q) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_write_o = resp_write_q;
    assign resp_hit_o   = resp_hit_q;
    assign resp_dirty_o = resp_dirty_q;
    assign resp_rdata_o = resp_rdata_q;
    assign arid_o       = ID_W'(ID);
    assign awid_o       = ID_W'(ID);
    assign wid_o        = ID_W'(ID);
    assign araddr_o     = addr_q;
    assign awaddr_o     = addr_q;
    assign wdata_o      = wdata_q;
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign awvalid_o    = awvalid_q;
    assign wvalid_o     = wvalid_q;
    assign bready_o     = bready_q;

endmodule

// File: tb/tb_dcache_lookup_master.sv
// -----------------------------------------------------------------------------
// tb_dcache_lookup_master
//
// Directed bench for dcache_lookup_master. A table of transactions is driven
// through one task that plays both the core and the storage slave. A small
// line store records completed fills and supplies later read beats. Some
// entries instead return a hand-built beat, to cover the dirty and valid=0
// cases. Hand-written sequences cover reset in the middle of a transaction
// and, when DCACHE_LOOKUP_STATS_EN is defined, the statistics counters.
// -----------------------------------------------------------------------------
module tb_dcache_lookup_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid_i, req_write_i, resp_ready_i;
    logic [63:0]  req_addr_i;
    logic [511:0] req_wdata_i;
    logic         req_ready_o, resp_valid_o, resp_write_o, resp_hit_o, resp_dirty_o;
    logic [511:0] resp_rdata_o;
    logic [15:0]  arid_o, awid_o, wid_o, rid_i, bid_i;
    logic [63:0]  araddr_o, awaddr_o;
    logic         arvalid_o, arready_i, rvalid_i, rready_o;
    logic [575:0] rdata_i;
    logic         awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
    logic [511:0] wdata_o;
`ifdef DCACHE_LOOKUP_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dcache_lookup_master dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_write_o(resp_write_o),
        .resp_hit_o(resp_hit_o), .resp_dirty_o(resp_dirty_o), .resp_rdata_o(resp_rdata_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
`ifdef DCACHE_LOOKUP_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    typedef struct {
        logic         write;
        logic [63:0]  addr;
        logic [511:0] wdata;
        logic         inj;       // return beat instead of the line store
        logic [575:0] beat;
        int           dly;       // slave stall cycles per channel
        int           rsp_dly;   // cycles the core withholds resp_ready_i
        logic         exp_write;
        logic         exp_hit;
        logic         exp_dirty;
        logic [511:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];

    // Line store of the bench slave, indexed by addr[31:6].
    logic [575:0] mem [logic [25:0]];

    task automatic check(input string nm, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic sel_sig(input int w);
        case (w)
            0:       return arvalid_o;
            1:       return rready_o;
            2:       return awvalid_o;
            3:       return wvalid_o;
            4:       return bready_o;
            default: return resp_valid_o;
        endcase
    endfunction

    // Wait, for at most 50 cycles, until the selected output is high. An
    // expired wait is reported as a failed comparison.
    task automatic wait_hi(input int w, input string nm);
        int n = 0;
        while (sel_sig(w) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(nm, 576'(sel_sig(w)), 576'(1'b1));
    endtask

    function automatic vec_t mk(input logic w, input logic [63:0] a, input logic [511:0] d,
                                input logic inj, input logic [575:0] b, input int dly,
                                input int rd, input logic ew, input logic eh, input logic ed,
                                input logic [511:0] er);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = d; v.inj = inj; v.beat = b;
        v.dly = dly; v.rsp_dly = rd;
        v.exp_write = ew; v.exp_hit = eh; v.exp_dirty = ed; v.exp_rdata = er;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        logic [575:0] beat;
        @(negedge clk);
        check("req_ready_idle", 576'(req_ready_o), 576'(1'b1));
        req_valid_i = 1'b1;
        req_write_i = v.write;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        @(negedge clk);
        req_valid_i = 1'b0;
        check("req_ready_busy", 576'(req_ready_o), 576'(1'b0));
        if (!v.write) begin
            wait_hi(0, "arvalid_rise");
            check("araddr", 576'(araddr_o), 576'(v.addr));
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                check("arvalid_hold", 576'(arvalid_o), 576'(1'b1));
                check("araddr_hold", 576'(araddr_o), 576'(v.addr));
                rvalid_i = 1'b1;            // stray beat, must be ignored
                rdata_i  = '1;
            end
            rvalid_i  = 1'b0;
            arready_i = 1'b1;
            @(negedge clk);
            arready_i = 1'b0;
            check("arvalid_drop", 576'(arvalid_o), 576'(1'b0));
            wait_hi(1, "rready_rise");
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                check("rready_hold", 576'(rready_o), 576'(1'b1));
            end
            if (v.inj) beat = v.beat;
            else if (mem.exists(v.addr[31:6])) beat = mem[v.addr[31:6]];
            else beat = '0;
            rvalid_i = 1'b1;
            rdata_i  = beat;
            check("resp_before_r", 576'(resp_valid_o), 576'(1'b0));
            @(negedge clk);
            rvalid_i = 1'b0;
            rdata_i  = '0;
            check("resp_latency_r", 576'(resp_valid_o), 576'(1'b1));
        end else begin
            wait_hi(2, "awvalid_rise");
            check("awaddr", 576'(awaddr_o), 576'(v.addr));
            check("w_before_aw", 576'(wvalid_o), 576'(1'b0));
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                check("awvalid_hold", 576'(awvalid_o), 576'(1'b1));
                check("awaddr_hold", 576'(awaddr_o), 576'(v.addr));
                check("w_before_aw", 576'(wvalid_o), 576'(1'b0));
                bvalid_i = 1'b1;            // stray response, must be ignored
            end
            bvalid_i  = 1'b0;
            awready_i = 1'b1;
            @(negedge clk);
            awready_i = 1'b0;
            check("awvalid_drop", 576'(awvalid_o), 576'(1'b0));
            wait_hi(3, "wvalid_rise");
            check("wdata", 576'(wdata_o), 576'(v.wdata));
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                check("wvalid_hold", 576'(wvalid_o), 576'(1'b1));
                check("wdata_hold", 576'(wdata_o), 576'(v.wdata));
            end
            wready_i = 1'b1;
            @(negedge clk);
            wready_i = 1'b0;
            check("wvalid_drop", 576'(wvalid_o), 576'(1'b0));
            wait_hi(4, "bready_rise");
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                check("bready_hold", 576'(bready_o), 576'(1'b1));
            end
            bvalid_i = 1'b1;
            check("resp_before_b", 576'(resp_valid_o), 576'(1'b0));
            @(negedge clk);
            bvalid_i = 1'b0;
            check("resp_latency_b", 576'(resp_valid_o), 576'(1'b1));
            mem[v.addr[31:6]] = {1'b1, 1'b0, v.addr[63:32], 30'h0, v.wdata};
        end
        check("resp_write", 576'(resp_write_o), 576'(v.exp_write));
        check("resp_hit", 576'(resp_hit_o), 576'(v.exp_hit));
        check("resp_dirty", 576'(resp_dirty_o), 576'(v.exp_dirty));
        check("resp_rdata", 576'(resp_rdata_o), 576'(v.exp_rdata));
        for (int i = 0; i < v.rsp_dly; i++) begin
            @(negedge clk);
            check("resp_hold_valid", 576'(resp_valid_o), 576'(1'b1));
            check("resp_hold_hit", 576'(resp_hit_o), 576'(v.exp_hit));
            check("resp_hold_rdata", 576'(resp_rdata_o), 576'(v.exp_rdata));
            check("req_ready_in_resp", 576'(req_ready_o), 576'(1'b0));
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        check("resp_drop", 576'(resp_valid_o), 576'(1'b0));
        check("req_ready_back", 576'(req_ready_o), 576'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] a5, c3, x3c, x5a, x0f;
        a5  = {64{8'hA5}};
        c3  = {64{8'hC3}};
        x3c = {64{8'h3C}};
        x5a = {64{8'h5A}};
        x0f = {64{8'h0F}};

        tbl[0] = mk(1'b1, 64'h0000_0012_0000_0040, a5, 1'b0, '0, 0, 0, 1'b1, 1'b0, 1'b0, '0);
        tbl[1] = mk(1'b0, 64'h0000_0012_0000_0040, '0, 1'b0, '0, 0, 0, 1'b0, 1'b1, 1'b0, a5);
        tbl[2] = mk(1'b0, 64'h0000_0013_0000_0040, '0, 1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, a5);
        tbl[3] = mk(1'b0, 64'h0000_0000_0000_1000, '0, 1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, '0);
        // Valid and dirty; reserved bits all set, so they must not affect the tag.
        tbl[4] = mk(1'b0, 64'h0000_0055_0000_0080, '0, 1'b1,
                    {1'b1, 1'b1, 32'h0000_0055, 30'h3FFF_FFFF, x3c}, 1, 0, 1'b0, 1'b1, 1'b1, x3c);
        // Tag matches but the valid bit is clear, so this is a miss.
        tbl[5] = mk(1'b0, 64'h0000_0066_0000_00C0, '0, 1'b1,
                    {1'b0, 1'b0, 32'h0000_0066, 30'h0, c3}, 0, 1, 1'b0, 1'b0, 1'b0, c3);
        tbl[6] = mk(1'b1, 64'h0000_00AB_0000_1FC0, x5a, 1'b0, '0, 5, 3, 1'b1, 1'b0, 1'b0, '0);
        tbl[7] = mk(1'b0, 64'h0000_00AB_0000_1FC0, '0, 1'b0, '0, 5, 3, 1'b0, 1'b1, 1'b0, x5a);
        tbl[8] = mk(1'b1, 64'hFFFF_FFFF_FFFF_FFC0, x0f, 1'b0, '0, 2, 0, 1'b1, 1'b0, 1'b0, '0);
        tbl[9] = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFC0, '0, 1'b0, '0, 2, 1, 1'b0, 1'b1, 1'b0, x0f);

        rst = 1'b1;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        resp_ready_i = 1'b0; arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rid_i = 16'h7;
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bid_i = 16'h9;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_req_ready", 576'(req_ready_o), 576'(1'b1));
        check("rst_valids", 576'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid_o}), 576'(6'b0));
        check("rst_araddr", 576'(araddr_o), 576'(64'h0));
        check("rst_resp_rdata", 576'(resp_rdata_o), 576'(512'h0));
        check("arid_const", 576'(arid_o), 576'(16'h1));

        for (int i = 0; i < NVEC; i++) run_txn(tbl[i]);

        // Reset taken while the fill is waiting in WR_W.
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b1;
        req_addr_i = 64'h0000_0077_0000_0200; req_wdata_i = {64{8'h77}};
        @(negedge clk);
        req_valid_i = 1'b0;
        wait_hi(2, "mid_awvalid");
        awready_i = 1'b1;
        @(negedge clk);
        awready_i = 1'b0;
        wait_hi(3, "mid_wvalid");
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valids", 576'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid_o}), 576'(6'b0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_req_ready", 576'(req_ready_o), 576'(1'b1));
        check("mid_rst_wvalid", 576'(wvalid_o), 576'(1'b0));
        run_txn(tbl[1]);

`ifdef DCACHE_LOOKUP_STATS_EN
        do_reset();
        check("stats_rst_hit", 576'(hit_cnt_o), 576'(32'd0));
        check("stats_rst_miss", 576'(miss_cnt_o), 576'(32'd0));
        run_txn(tbl[0]);
        run_txn(tbl[1]);
        run_txn(tbl[4]);
        run_txn(tbl[9]);
        run_txn(tbl[2]);
        run_txn(tbl[3]);
        check("stats_hit", 576'(hit_cnt_o), 576'(32'd3));
        check("stats_miss", 576'(miss_cnt_o), 576'(32'd2));
        @(negedge clk);
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        run_txn(tbl[1]);
        check("stats_hit_sat", 576'(hit_cnt_o), 576'(32'hFFFF_FFFF));
        check("stats_miss_after_sat", 576'(miss_cnt_o), 576'(32'd2));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
